// File: rtl/uart_tx_simple.sv
// uart_tx_simple: UART transmitter, one byte per frame (start, 8 data LSB first, optional parity, 1-2 stop bits)
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   tx_byte    byte to send, sampled on an accepted handshake
//   tx_valid   host offers tx_byte
//   tx_ready   block can accept a byte this cycle (registered)
//   serial_tx  UART line, idle high (registered)
//   tx_busy    frame in progress (registered)
//   tx_done    one-cycle pulse on the final clock of the last stop bit (registered)
// Build option: define UART_TX_FIFO_EN for a 4-entry input FIFO that chains frames with no idle gap.
module uart_tx_simple #(
   parameter int BAUD_RATE   = 115200,
   parameter int PARITY      = 0,
   parameter int STOP        = 1,
   parameter int CLK_FREQ_HZ = 33330000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       serial_tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(CPB - 1);
   localparam logic [2:0]    LAST_STOP = 3'(STOP - 1);

   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_simple: PARITY must be 0, 1 or 2");
   end
   if (STOP < 1 || STOP > 2) begin : g_bad_stop
      $error("uart_tx_simple: STOP must be 1 or 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic            tx_q, tx_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            bit_end;
   logic            avail;
   logic            take;
   logic [7:0]      head;

   assign bit_end = cnt_q == LAST_CNT;

`ifdef UART_TX_FIFO_EN
   logic [7:0] mem_q [4];
   logic [1:0] wr_q, rd_q;
   logic [2:0] fcnt_q, fcnt_d;
   logic       push;

   assign push    = tx_valid & ready_q;
   assign avail   = fcnt_q != 3'd0;
   assign head    = mem_q[rd_q];
   assign fcnt_d  = fcnt_q + {2'b00, push} - {2'b00, take};
   assign ready_d = fcnt_d != 3'd4;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= tx_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
      end else begin
         wr_q   <= wr_q + {1'b0, push};
         rd_q   <= rd_q + {1'b0, take};
         fcnt_q <= fcnt_d;
      end
   end
`else
   // Without the FIFO, ready is only high in IDLE, so a byte can never be taken mid-frame.
   assign avail   = tx_valid & ready_q;
   assign head    = tx_byte;
   assign ready_d = state_d == S_IDLE;
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_d   = bit_q;
      take    = 1'b0;
      case (state_q)
         S_IDLE:  take = avail;
         S_START: if (bit_end) state_d = S_DATA;
         S_DATA:  if (bit_end) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (PARITY != 0) ? S_PAR : S_STOP;
         end
         S_PAR:   if (bit_end) state_d = S_STOP;
         S_STOP:  if (bit_end) begin
            bit_d = (bit_q == LAST_STOP) ? 3'd0 : bit_q + 3'd1;
            if (bit_q == LAST_STOP) begin
               state_d = S_IDLE;
               take    = avail;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         state_d = S_START;
         shift_d = head;
         par_d   = (PARITY == 1) ? ~^head : ^head;
      end
      cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      // Outputs are derived from next state so the registered line moves in step with the FSM.
      tx_d    = (state_d == S_START) ? 1'b0 :
                (state_d == S_DATA)  ? shift_d[0] :
                (state_d == S_PAR)   ? par_d : 1'b1;
      busy_d  = state_d != S_IDLE;
      done_d  = (state_d == S_STOP) && (bit_d == LAST_STOP) && (cnt_d == LAST_CNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign serial_tx = tx_q;
   assign tx_ready  = ready_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;
endmodule

// File: tb/tb_uart_tx_simple.sv
// tb_uart_tx_simple: scoreboard bench for uart_tx_simple across parity and stop-bit settings
module tb_uart_tx_simple;
   localparam int CPB = 289;
`ifdef UART_TX_FIFO_EN
   localparam int GAP2 = 2890;
`else
   localparam int GAP2 = 2891;
`endif

   typedef struct {
      int         k;
      logic [7:0] d;
      logic       p;
      int         gap;
      bit         ab;
   } exp_t;

   logic       clk = 1'b0;
   logic [3:0] rn  = 4'h0;
   logic [3:0] vld = 4'h0;
   logic [3:0] rdy, sx, busy, done;
   logic [7:0] byt [4];
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   exp_t       q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_simple u0 (.clk(clk), .rst_n(rn[0]), .tx_byte(byt[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
                      .serial_tx(sx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx_simple #(.PARITY(2)) u1 (.clk(clk), .rst_n(rn[1]), .tx_byte(byt[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
                      .serial_tx(sx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx_simple #(.PARITY(1)) u2 (.clk(clk), .rst_n(rn[2]), .tx_byte(byt[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
                      .serial_tx(sx[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_tx_simple #(.STOP(2)) u3 (.clk(clk), .rst_n(rn[3]), .tx_byte(byt[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
                      .serial_tx(sx[3]), .tx_busy(busy[3]), .tx_done(done[3]));

   task automatic chk(input string nm, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic mon(input int k, input int npar, input int nstop);
      int last = -1;
      forever begin
         @(negedge clk);
         if (rn[k] && !sx[k]) begin
            int          st, f, bad, dbad;
            bit          ab;
            logic [11:0] fb, act;
            exp_t        e;
            st = cyc;
            if (q.size() == 0 || q[0].k != k) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: unit %0d started a frame at cycle %0d, none expected", k, st);
               while (!sx[k] && rn[k]) @(negedge clk);
               continue;
            end
            e = q.pop_front();
            f = (9 + npar + nstop) * CPB;
            fb = '1;
            fb[0] = 1'b0;
            fb[8:1] = e.d;
            if (npar != 0) fb[9] = e.p;
            act = '1;
            bad = 0;
            dbad = 0;
            ab = 1'b0;
            for (int j = 0; j < f; j++) begin
               if (j > 0) @(negedge clk);
               if (!rn[k]) begin
                  ab = 1'b1;
                  break;
               end
               if (sx[k] != fb[j / CPB]) bad++;
               if (j % CPB == CPB / 2) act[j / CPB] = sx[k];
               if (done[k] != (j == f - 1)) dbad++;
            end
            chk($sformatf("aborted_u%0d", k), int'(ab), int'(e.ab));
            chk($sformatf("done_pulse_u%0d", k), dbad, 0);
            if (!ab) begin
               chk($sformatf("frame_bits_u%0d", k), int'(act), int'(fb));
               chk($sformatf("bit_hold_u%0d", k), bad, 0);
               if (e.gap != 0) chk($sformatf("start_gap_u%0d", k), st - last, e.gap);
            end else begin
               while (!rn[k]) @(negedge clk);
            end
            last = st;
         end
      end
   endtask

   task automatic offer(input int k, input logic [7:0] d, input logic p, input int gap, input bit ab);
      int n = 0;
      @(negedge clk);
      while (!rdy[k] && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) chk("offer_timeout", 0, 1);
      q.push_back('{k, d, p, gap, ab});
      vld[k] = 1'b1;
      byt[k] = d;
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
      byt[k] = ~d;
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(q.size() == 0 && !busy[k]) && n < 20000);
      if (n >= 20000) chk("idle_timeout", 0, 1);
      chk($sformatf("line_idle_u%0d", k), int'(sx[k]), 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) byt[i] = 8'h00;
      fork
         mon(0, 0, 1);
         mon(1, 1, 1);
         mon(2, 1, 1);
         mon(3, 0, 2);
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_serial_tx", int'(sx), 'hF);
      chk("reset_tx_ready", int'(rdy), 'hF);
      chk("reset_tx_busy", int'(busy), 0);
      chk("reset_tx_done", int'(done), 0);
      rn = 4'hF;
      offer(0, 8'h88, 1'b0, 0, 1'b0);
      wait_idle(0);
      offer(1, 8'h88, 1'b0, 0, 1'b0);
      wait_idle(1);
      offer(2, 8'h88, 1'b1, 0, 1'b0);
      wait_idle(2);
      offer(2, 8'h07, 1'b0, 0, 1'b0);
      wait_idle(2);
      offer(3, 8'hFF, 1'b0, 0, 1'b0);
      wait_idle(3);
      begin
         int n = 0;
         @(negedge clk);
         q.push_back('{0, 8'h55, 1'b0, 0, 1'b0});
         q.push_back('{0, 8'hA3, 1'b0, GAP2, 1'b0});
         vld[0] = 1'b1;
         byt[0] = 8'h55;
         @(posedge clk);
         #1;
         byt[0] = 8'hA3;
         @(negedge clk);
         while (!rdy[0] && n < 5000) begin
            @(negedge clk);
            n++;
         end
         chk("second_offer_ready", int'(rdy[0]), 1);
         @(posedge clk);
         #1;
         vld[0] = 1'b0;
         byt[0] = 8'h00;
      end
      wait_idle(0);
      offer(0, 8'h11, 1'b0, 0, 1'b1);
      repeat (1000) @(posedge clk);
      #3;
      rn[0] = 1'b0;
      #1;
      chk("mid_reset_serial_tx", int'(sx[0]), 1);
      chk("mid_reset_tx_busy", int'(busy[0]), 0);
      chk("mid_reset_tx_done", int'(done[0]), 0);
      repeat (3) @(negedge clk);
      rn[0] = 1'b1;
      offer(0, 8'h3C, 1'b0, 0, 1'b0);
      wait_idle(0);
`ifndef UART_TX_FIFO_EN
      offer(0, 8'h5A, 1'b0, 0, 1'b0);
      repeat (500) @(negedge clk);
      chk("busy_tx_ready", int'(rdy[0]), 0);
      vld[0] = 1'b1;
      byt[0] = 8'hFF;
      @(negedge clk);
      vld[0] = 1'b0;
      wait_idle(0);
      repeat (50) @(negedge clk);
      chk("no_extra_frame_busy", int'(busy[0]), 0);
`endif
      repeat (20) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
